// File: rtl/csea_pipe.sv
// rtl/csea_pipe.sv - pipelined carry-select adder/subtractor, one BLOCK-bit slice resolved per stage
// Stage 0 latches operands; stage k+1 adds the selected sum of block k and its carry-out.
module csea_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             co,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  if (WIDTH < 2 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("csea_pipe: WIDTH must be >= 2 and an integer multiple of BLOCK");
  end

  // Returns {carry_out, sum} of a plain ripple chain.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] a,
                                            input logic [BLOCK-1:0] b,
                                            input logic             cin);
    logic [BLOCK-1:0] s;
    logic             c;
    s = '0;
    c = cin;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic             en;
  logic [NBLK:0]    v_q;
  logic [NBLK:0]    c_q;
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] s_q   [1:NBLK];
  logic [WIDTH-1:0] snext [NBLK];
  logic [BLOCK-1:0] bsum  [NBLK];
  logic [NBLK-1:0]  bco;
  logic             cmsb;
  logic             ovf_q;

  assign en       = !v_q[NBLK] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLOCK-1:0] ak;
    logic [BLOCK-1:0] bk;
    logic [BLOCK:0]   r0;
    logic [BLOCK:0]   r1;

    assign ak      = a_q[k][k*BLOCK +: BLOCK];
    assign bk      = b_q[k][k*BLOCK +: BLOCK];
    assign r0      = ripple(ak, bk, 1'b0);
    assign r1      = ripple(ak, bk, 1'b1);
    assign bsum[k] = c_q[k] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
    assign bco[k]  = r0[BLOCK] | (r1[BLOCK] & c_q[k]);

    // Blocks above k are still zero in s_q, so OR-ing in the new slice is exact.
    if (k == 0) begin : g_first
      assign snext[k] = WIDTH'(bsum[k]);
    end else begin : g_rest
      assign snext[k] = s_q[k] | (WIDTH'(bsum[k]) << (k*BLOCK));
    end

    // Carry into the MSB recovered from the selected sum bit of the top block.
    if (k == NBLK-1) begin : g_last
      assign cmsb = bsum[k][BLOCK-1] ^ ak[BLOCK-1] ^ bk[BLOCK-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= NBLK; k++) begin
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q    <= {v_q[NBLK-1:0], in_valid};
      c_q    <= {bco, ci ^ sub};
      a_q[0] <= x;
      b_q[0] <= sub ? ~y : y;
      for (int k = 1; k < NBLK; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= NBLK; k++) begin
        s_q[k] <= snext[k-1];
      end
      ovf_q <= cmsb ^ bco[NBLK-1];
    end
  end

  assign z         = s_q[NBLK];
  assign co        = c_q[NBLK];
  assign ovf       = ovf_q;
  assign out_valid = v_q[NBLK];

endmodule

// File: tb/tb_csea_pipe.sv
// tb/tb_csea_pipe.sv - self-checking bench for csea_pipe at (8,4), (32,8) and (16,16)
// Arithmetic reference model plus scoreboard, directed literal cases and random regression.
module tb_csea_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  in_valid;
  logic [2:0]  ci;
  logic [2:0]  sub;
  logic [2:0]  out_ready;
  logic [31:0] x [3];
  logic [31:0] y [3];
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  co;
  logic [2:0]  ovf;
  logic [31:0] zz [3];

  logic ir0, ov0, co0, of0;
  logic ir1, ov1, co1, of1;
  logic ir2, ov2, co2, of2;
  logic [7:0]  z0;
  logic [31:0] z1;
  logic [15:0] z2;

  csea_pipe #(.WIDTH(8), .BLOCK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0),
    .x(x[0][7:0]), .y(y[0][7:0]), .ci(ci[0]), .sub(sub[0]),
    .out_valid(ov0), .out_ready(out_ready[0]), .z(z0), .co(co0), .ovf(of0));

  csea_pipe #(.WIDTH(32), .BLOCK(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1),
    .x(x[1]), .y(y[1]), .ci(ci[1]), .sub(sub[1]),
    .out_valid(ov1), .out_ready(out_ready[1]), .z(z1), .co(co1), .ovf(of1));

  csea_pipe #(.WIDTH(16), .BLOCK(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir2),
    .x(x[2][15:0]), .y(y[2][15:0]), .ci(ci[2]), .sub(sub[2]),
    .out_valid(ov2), .out_ready(out_ready[2]), .z(z2), .co(co2), .ovf(of2));

  assign in_ready  = {ir2, ir1, ir0};
  assign out_valid = {ov2, ov1, ov0};
  assign co        = {co2, co1, co0};
  assign ovf       = {of2, of1, of0};
  assign zz[0]     = {24'h0, z0};
  assign zz[1]     = z1;
  assign zz[2]     = {16'h0, z2};

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] q [3][$];
  logic [33:0] held [3];
  bit   [2:0]  stall_prev = '0;

  function automatic int wd(input int c);
    return (c == 0) ? 8 : (c == 1) ? 32 : 16;
  endfunction

  function automatic int nb(input int c);
    return (c == 0) ? 2 : (c == 1) ? 4 : 1;
  endfunction

  // {ovf, co, z}: plain wide addition, overflow from operand/result signs.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c,
                                        input logic s);
    logic [31:0] m, aa, bb, r;
    logic [32:0] full;
    logic        cy, ov;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    aa   = a & m;
    bb   = (s ? ~b : b) & m;
    full = {1'b0, aa} + {1'b0, bb} + {32'h0, c ^ s};
    r    = full[31:0] & m;
    cy   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {ov, cy, r};
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        q[c].delete();
        stall_prev[c] = 1'b0;
      end else begin
        if (in_valid[c] && in_ready[c])
          q[c].push_back(model(wd(c), x[c], y[c], ci[c], sub[c]));
        chk($sformatf("in_ready_cfg%0d", c), 36'(in_ready[c]),
            36'(!out_valid[c] || out_ready[c]));
        if (stall_prev[c])
          chk($sformatf("stall_hold_cfg%0d", c),
              {1'b0, out_valid[c], ovf[c], co[c], zz[c]}, {1'b0, 1'b1, held[c]});
        if (out_valid[c] && out_ready[c]) begin
          if (q[c].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result_cfg%0d: got z=%h with nothing outstanding", c, zz[c]);
          end else begin
            chk($sformatf("result_cfg%0d", c), {2'b0, ovf[c], co[c], zz[c]},
                {2'b0, q[c].pop_front()});
          end
        end
        stall_prev[c] = out_valid[c] && !out_ready[c];
        held[c]       = {ovf[c], co[c], zz[c]};
      end
    end
  end

  task automatic send_one(input int c, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic s, input logic [31:0] ez,
                          input logic eco, input logic eovf, input string nm);
    int k;
    @(posedge clk); #1;
    out_ready[c] = 1'b1;
    in_valid[c]  = 1'b1;
    x[c] = a; y[c] = b; ci[c] = cin; sub[c] = s;
    chk({nm, "_in_ready"}, 36'(in_ready[c]), 36'(1));
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
    k = 0;
    while (!out_valid[c] && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_latency"}, 36'(k), 36'(nb(c)));
    chk({nm, "_result"}, {2'b0, ovf[c], co[c], zz[c]}, {2'b0, eovf, eco, ez});
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int          i, hold;
    bit          started;
    logic [31:0] got [$];

    in_valid  = '0;
    ci        = '0;
    sub       = '0;
    out_ready = '1;
    for (int c = 0; c < 3; c++) begin
      x[c] = '0;
      y[c] = '0;
    end

    // Reset state, checked while rst is still asserted.
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++)
      chk($sformatf("reset_state_cfg%0d", c),
          {out_valid[c], in_ready[c], ovf[c], co[c], zz[c]}, {1'b0, 1'b1, 34'h0});
    @(posedge clk); #1;
    rst = 1'b0;

    chk("model_pin_add8", 36'(model(8, 32'd157, 32'd105, 1'b0, 1'b0)), {2'b0, 1'b0, 1'b1, 32'h06});
    chk("model_pin_sub8", 36'(model(8, 32'h80, 32'h01, 1'b0, 1'b1)), {2'b0, 1'b1, 1'b1, 32'h7F});

    send_one(0, 32'd157, 32'd105, 1'b0, 1'b0, 32'h06, 1'b1, 1'b0, "add_157_105");
    send_one(0, 32'd5,   32'd7,   1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, "sub_5_7");
    send_one(0, 32'h7F,  32'h01,  1'b0, 1'b0, 32'h80, 1'b0, 1'b1, "add_7f_1");
    send_one(0, 32'h80,  32'h01,  1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, "sub_80_1");
    send_one(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "carry_chain32");
    send_one(1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf32");
    send_one(2, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "sub16_single");
    send_one(2, 32'hFFFF, 32'h0001, 1'b1, 1'b0, 32'h0001, 1'b1, 1'b0, "add16_single");

    // Backpressure: four ops streamed, output held off for three cycles.
    i = 0; hold = 0; started = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        in_valid[0] = 1'b1;
        x[0] = 32'(i + 1); y[0] = 32'(i + 1); ci[0] = 1'b0; sub[0] = 1'b0;
      end else begin
        in_valid[0] = 1'b0;
      end
      if (!started && out_valid[0]) begin
        started = 1'b1;
        hold    = 3;
      end
      out_ready[0] = (hold == 0);
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) i++;
      if (hold > 0) begin
        chk("bp_in_ready_low", {34'h0, out_valid[0], in_ready[0]}, 36'h2);
        chk("bp_z_held", 36'(zz[0]), 36'd2);
        hold--;
      end
      if (out_valid[0] && out_ready[0]) got.push_back(zz[0]);
    end
    in_valid[0] = 1'b0;
    chk("bp_count", 36'(got.size()), 36'd4);
    for (int j = 0; j < got.size() && j < 4; j++)
      chk($sformatf("bp_order_%0d", j), 36'(got[j]), 36'(2 * (j + 1)));

    // Async reset with two ops in flight.
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1; x[0] = 32'd50; y[0] = 32'd60; ci[0] = 1'b0; sub[0] = 1'b0;
    @(posedge clk); #1;
    x[0] = 32'd70; y[0] = 32'd1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #3;
    chk("pre_rst_out", {out_valid[0], 35'(zz[0])}, {1'b1, 35'd110});
    rst = 1'b1;
    #1;
    chk("rst_async", {out_valid[0], in_ready[0], ovf[0], co[0], zz[0]}, {1'b0, 1'b1, 34'h0});
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_quiet", 36'(out_valid[0]), 36'd0);
    end
    send_one(0, 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, "post_rst_op");

    // Random regression, one configuration at a time.
    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < 10000; t++) begin
        @(posedge clk); #1;
        in_valid[c]  = ($urandom_range(0, 3) != 0);
        x[c]         = $urandom;
        y[c]         = $urandom;
        ci[c]        = 1'($urandom);
        sub[c]       = 1'($urandom);
        out_ready[c] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid[c]  = 1'b0;
      out_ready[c] = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk($sformatf("drain_empty_cfg%0d", c), 36'(q[c].size()), 36'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
